// File: rtl/multicycle_alu.sv
// Handshaked RV32IM-style execution unit: single-cycle logic ops, iterative shift-add multiply
// and restoring divide. The divider is only built when MULTICYCLE_ALU_DIV_EN is defined.
module multicycle_alu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  typedef logic [OPCODE_LENGTH-1:0] op_t;
  localparam op_t OP_AND   = op_t'(0);
  localparam op_t OP_SUB   = op_t'(1);
  localparam op_t OP_ADD   = op_t'(2);
  localparam op_t OP_OR    = op_t'(3);
  localparam op_t OP_XOR   = op_t'(4);
  localparam op_t OP_SLL   = op_t'(5);
  localparam op_t OP_SRL   = op_t'(6);
  localparam op_t OP_SRA   = op_t'(7);
  localparam op_t OP_EQ    = op_t'(8);
  localparam op_t OP_SLT   = op_t'(9);
  localparam op_t OP_SLTU  = op_t'(10);
  localparam op_t OP_MUL   = op_t'(11);
  localparam op_t OP_MULH  = op_t'(12);
  localparam op_t OP_MULHU = op_t'(13);
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam op_t OP_DIV   = op_t'(14);
  localparam op_t OP_DIVU  = op_t'(15);
  localparam op_t OP_REM   = op_t'(16);
  localparam op_t OP_REMU  = op_t'(17);
`endif

  typedef enum logic [2:0] {
    IDLE, MUL, FIX, DONE
`ifdef MULTICYCLE_ALU_DIV_EN
    , DIV
`endif
  } state_t;

  state_t         state, state_n, dest;
  logic [SW-1:0]  cnt;
  op_t            op_q;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mc;
  logic           neg_q;
  logic           accept, is_mul, iter, last_iter, sgn_op, a_neg, b_neg;
  logic [2*W-1:0] prod_c;
  logic [W-1:0]   fix_res;
`ifdef MULTICYCLE_ALU_DIV_EN
  logic           is_div, neg_r, bz;
  logic [W-1:0]   opa;
`endif

  function automatic logic [W-1:0] simple_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] as, bs;
    logic [SW-1:0]       sh;
    as = a;
    bs = b;
    sh = b[SW-1:0];
    case (op)
      OP_AND:  simple_op = a & b;
      OP_SUB:  simple_op = a - b;
      OP_ADD:  simple_op = a + b;
      OP_OR:   simple_op = a | b;
      OP_XOR:  simple_op = a ^ b;
      OP_SLL:  simple_op = a << sh;
      OP_SRL:  simple_op = a >> sh;
      OP_SRA:  simple_op = as >>> sh;
      OP_EQ:   simple_op = W'(a == b);
      OP_SLT:  simple_op = W'(as < bs);
      OP_SLTU: simple_op = W'(a < b);
      default: simple_op = W'(1);
    endcase
  endfunction

  function automatic logic [W-1:0] cneg(input logic [W-1:0] x, input logic n);
    cneg = n ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] cneg2(input logic [2*W-1:0] x, input logic n);
    cneg2 = n ? -x : x;
  endfunction

  // {high accumulator, multiplier}: add multiplicand when the current multiplier bit is set, shift right.
  function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : {(W+1){1'b0}});
    mul_step = {s, p[W-1:1]};
  endfunction

`ifdef MULTICYCLE_ALU_DIV_EN
  // {partial remainder, dividend/quotient}: shift in the next dividend bit, keep the difference if non-negative.
  function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [W:0] sh, df;
    sh = {p[2*W-1:W], p[W-1]};
    df = sh - {1'b0, m};
    if (!df[W]) div_step = {df[W-1:0], p[W-2:0], 1'b1};
    else        div_step = {sh[W-1:0], p[W-2:0], 1'b0};
  endfunction
`endif

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign is_mul    = (Operation == OP_MUL) || (Operation == OP_MULH) || (Operation == OP_MULHU);
`ifdef MULTICYCLE_ALU_DIV_EN
  assign is_div    = (Operation == OP_DIV) || (Operation == OP_DIVU) ||
                     (Operation == OP_REM) || (Operation == OP_REMU);
  assign iter      = (state == MUL) || (state == DIV);
  assign sgn_op    = (Operation == OP_MULH) || (Operation == OP_DIV) || (Operation == OP_REM);
`else
  assign iter      = (state == MUL);
  assign sgn_op    = (Operation == OP_MULH);
`endif
  assign last_iter = iter && (cnt == SW'(W - 1));
  assign a_neg     = sgn_op && SrcA[W-1];
  assign b_neg     = sgn_op && SrcB[W-1];

  always_comb begin
    dest = DONE;
    if (is_mul) dest = MUL;
`ifdef MULTICYCLE_ALU_DIV_EN
    else if (is_div) dest = DIV;
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = dest;
      MUL:     if (last_iter) state_n = FIX;
`ifdef MULTICYCLE_ALU_DIV_EN
      DIV:     if (last_iter) state_n = FIX;
`endif
      FIX:     state_n = DONE;
      DONE:    if (accept) state_n = dest;
               else if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (iter) cnt <= last_iter ? '0 : cnt + SW'(1);
    else           cnt <= '0;
  end

  // Operand capture and iteration datapath; operands are stored as magnitudes, signs fixed up at FIX.
  always_ff @(posedge clk) begin
    if (accept) op_q <= Operation;
    if (accept && is_mul) begin
      acc   <= {{W{1'b0}}, cneg(SrcB, b_neg)};
      mc    <= cneg(SrcA, a_neg);
      neg_q <= a_neg ^ b_neg;
    end
`ifdef MULTICYCLE_ALU_DIV_EN
    else if (accept && is_div) begin
      acc   <= {{W{1'b0}}, cneg(SrcA, a_neg)};
      mc    <= cneg(SrcB, b_neg);
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      bz    <= (SrcB == '0);
      opa   <= SrcA;
    end
    else if (state == DIV) acc <= div_step(acc, mc);
`endif
    else if (state == MUL) acc <= mul_step(acc, mc);
  end

  always_comb begin
    fix_res = '0;
    prod_c  = cneg2(acc, neg_q);
    case (op_q)
      OP_MUL:   fix_res = prod_c[W-1:0];
      OP_MULH:  fix_res = prod_c[2*W-1:W];
      OP_MULHU: fix_res = acc[2*W-1:W];
`ifdef MULTICYCLE_ALU_DIV_EN
      OP_DIV:   fix_res = bz ? '1  : cneg(acc[W-1:0], neg_q);
      OP_DIVU:  fix_res = bz ? '1  : acc[W-1:0];
      OP_REM:   fix_res = bz ? opa : cneg(acc[2*W-1:W], neg_r);
      OP_REMU:  fix_res = bz ? opa : acc[2*W-1:W];
`endif
      default:  fix_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                       ALUResult <= '0;
    else if (accept && dest == DONE) ALUResult <= simple_op(Operation, SrcA, SrcB);
    else if (state == FIX)           ALUResult <= fix_res;
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed scenarios plus randomized ops checked against
// a plain-arithmetic reference model; a monitor pops expected results as the DUT presents them.
module tb_multicycle_alu;
  localparam int W        = 32;
  localparam int ITER_LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid;
  logic [W-1:0] SrcA = '0, SrcB = '0, ALUResult;
  logic [4:0]   Operation = '0;

  always #5 clk = ~clk;

  multicycle_alu #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult)
  );

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    logic [4:0]   op;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;
  bit   rdy_force = 1'b1;
  bit   mon_off = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb_, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb_ = $signed(b);
    ua = a;
    ub = b;
    case (op)
      5'd0:  return a & b;
      5'd1:  return a - b;
      5'd2:  return a + b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return $signed(a) >>> b[4:0];
      5'd8:  return (a == b) ? 32'd1 : 32'd0;
      5'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10: return (a < b) ? 32'd1 : 32'd0;
      5'd11: begin p = sa * sb_; return p[31:0]; end
      5'd12: begin p = sa * sb_; return p[63:32]; end
      5'd13: begin p = ua * ub; return p[63:32]; end
`ifdef MULTICYCLE_ALU_DIV_EN
      5'd14: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb_; p = q; return p[31:0];
      end
      5'd15: return (b == 0) ? '1 : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb_; p = q; return p[31:0];
      end
      5'd17: return (b == 0) ? a : a % b;
`endif
      default: return 32'd1;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] op);
    if (op >= 5'd11 && op <= 5'd13) return ITER_LAT;
`ifdef MULTICYCLE_ALU_DIV_EN
    if (op >= 5'd14 && op <= 5'd17) return ITER_LAT;
`endif
    return 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one request, wait (bounded) for acceptance, then record its expected response.
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    exp_t e;
    in_valid = 1'b1;
    Operation = op;
    SrcA = a;
    SrcB = b;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout op=0x%0h in_ready=%0b required=1", op, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.res = model(op, a, b);
    e.lat = lat_of(op);
    e.acc = cyc;
    e.op  = op;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: pops on every consumed result and checks hold stability and in_ready while busy.
  bit           have_first = 1'b0;
  bit           have_hold = 1'b0;
  int           first_cyc = 0;
  logic [W-1:0] hold_res = '0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_off) begin
      have_first = 1'b0;
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_result", ALUResult, hold_res);
      end
      if (out_valid) begin
        if (!have_first) begin
          have_first = 1'b1;
          first_cyc = cyc;
        end
        if (!out_ready) check("hold_in_ready", in_ready, 0);
        else begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=0x%0h required=no output", ALUResult);
          end else begin
            e = sb.pop_front();
            check($sformatf("result_op%0h", e.op), ALUResult, e.res);
            check($sformatf("latency_op%0h", e.op), first_cyc - e.acc + 1, e.lat);
          end
          have_first = 1'b0;
        end
      end else if (sb.size() != 0) begin
        check("busy_in_ready", in_ready, 0);
      end
      have_hold = out_valid && !out_ready;
      hold_res = ALUResult;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [4:0]   rop;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", ALUResult, 0);
    check("reset_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mon_off = 1'b0;

    // Back-to-back single-cycle ops with the consumer always ready.
    send(5'd2, 32'd5, 32'd7, w);
    check("b2b_wait_add", w, 0);
    send(5'd7, 32'h8000_0000, 32'd4, w);
    check("b2b_wait_sra", w, 0);
    send(5'd9, 32'hFFFF_FFFF, 32'd1, w);
    send(5'd10, 32'hFFFF_FFFF, 32'd1, w);
    send(5'd8, 32'd9, 32'd9, w);

    send(5'd11, 32'hFFFF_FFFF, 32'd2, w);
    send(5'd12, 32'hFFFF_FFFF, 32'd2, w);
    send(5'd13, 32'hFFFF_FFFF, 32'd2, w);

    send(5'd14, -32'sd7, 32'd2, w);
    send(5'd16, -32'sd7, 32'd2, w);
    send(5'd15, 32'd7, 32'd0, w);
    send(5'd17, 32'd7, 32'd0, w);
    send(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, w);
    send(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, w);
    send(5'd14, 32'd8, 32'd2, w);
    wait_drain(500);

    // Backpressure: result must hold for five cycles and a request pulse must be refused.
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    send(5'd2, 32'h11, 32'h22, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", ALUResult, model(5'd2, 32'h11, 32'h22));
      check("bp_in_ready", in_ready, 0);
      if (i == 2) begin
        in_valid = 1'b1;
        Operation = 5'd4;
        SrcA = 32'hDEAD_BEEF;
        SrcB = 32'h1234_5678;
      end
      if (i == 3) in_valid = 1'b0;
      if (i == 4) rdy_force = 1'b1;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_consumed", out_valid, 0);
    check("bp_queue_empty", sb.size(), 0);
    @(posedge clk);
    #1;

    // Reset ten cycles into an iterative op abandons it.
`ifdef MULTICYCLE_ALU_DIV_EN
    send(5'd14, 32'd100, 32'd7, w);
`else
    send(5'd11, 32'd100, 32'd7, w);
`endif
    repeat (9) @(posedge clk);
    #1;
    mon_off = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_result", ALUResult, 0);
    check("rst_mid_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mon_off = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_stale", out_valid, 0);
    send(5'd2, 32'd1, 32'd1, w);
    check("rst_add_wait", w, 0);
    wait_drain(100);

    // Randomized traffic with random consumer stalls and request gaps.
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      rop = 5'($urandom_range(0, 19));
      ra = pick();
      rb = pick();
      send(rop, ra, rb, w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_drain(3000);
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
